// File: rtl/zeroriscy_irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : zeroriscy_irq_controller
// Purpose  : Machine-mode interrupt controller: synchroniser, pending state,
//            fixed-priority arbitration, request/service tracking to MRET.
//            Define ZERORISCY_IRQ_EDGE_EN for edge-latched pending bits;
//            the default build is level-sensitive.
// Revision : 1.0 - initial release
// ============================================================================
module zeroriscy_irq_controller #(
    parameter int N_IRQ = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic             m_irq_enable_i,
    input  logic             irq_ack_i,
    input  logic             mret_i,
    output logic             irq_req_o,
    output logic [4:0]       irq_id_o,
    output logic [5:0]       csr_cause_o,
    output logic [N_IRQ-1:0] irq_pending_o,
    output logic             irq_in_service_o
);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_REQ     = 2'd1;
    localparam logic [1:0] c_SERVICE = 2'd2;

    logic [1:0]       r_state;
    logic [4:0]       r_id_q;
    logic             r_req;
    logic             r_in_service;

    logic [N_IRQ-1:0] r_sync1;
    logic [N_IRQ-1:0] r_sync2;
    logic [N_IRQ-1:0] w_pend;
    logic [4:0]       w_sel_id;
    logic             w_any_pend;

    // Two-flop synchroniser; r_sync2 is the clock-domain view of irq_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_i;
            r_sync2 <= r_sync1;
        end
    end

`ifdef ZERORISCY_IRQ_EDGE_EN
    logic [N_IRQ-1:0] r_sync_d;
    logic [N_IRQ-1:0] r_pend;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_clr;
    logic             w_ack_req;

    assign w_ack_req = (r_state == c_REQ) && irq_ack_i;
    assign w_rise    = r_sync2 & ~r_sync_d;

    always_comb begin
        w_clr = '0;
        for (int k = 0; k < N_IRQ; k++) begin
            if (w_ack_req && (r_id_q == 5'(k))) begin
                w_clr[k] = 1'b1;
            end
        end
    end

    // Set has priority over the ack clear so a coincident new edge is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_d <= '0;
            r_pend   <= '0;
        end else begin
            r_sync_d <= r_sync2;
            r_pend   <= (r_pend & ~w_clr) | w_rise;
        end
    end

    assign w_pend = r_pend;
`else
    assign w_pend = r_sync2;
`endif

    always_comb begin
        w_sel_id = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (w_pend[k]) begin
                w_sel_id = 5'(k);
            end
        end
    end

    assign w_any_pend = |w_pend;

    // The id is captured on entry to REQ and frozen until the next IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_id_q       <= '0;
            r_req        <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_any_pend && m_irq_enable_i) begin
                        r_state <= c_REQ;
                        r_id_q  <= w_sel_id;
                        r_req   <= 1'b1;
                    end
                end
                c_REQ: begin
                    if (irq_ack_i) begin
                        r_state      <= c_SERVICE;
                        r_req        <= 1'b0;
                        r_in_service <= 1'b1;
                    end else if (!m_irq_enable_i) begin
                        r_state <= c_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                c_SERVICE: begin
                    if (mret_i) begin
                        r_state      <= c_IDLE;
                        r_in_service <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= c_IDLE;
                    r_req        <= 1'b0;
                    r_in_service <= 1'b0;
                end
            endcase
        end
    end

    assign irq_req_o        = r_req;
    assign irq_id_o         = r_id_q;
    assign csr_cause_o      = {1'b1, r_id_q};
    assign irq_pending_o    = w_pend;
    assign irq_in_service_o = r_in_service;

endmodule
`default_nettype wire

// File: tb/tb_zeroriscy_irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_zeroriscy_irq_controller
// Purpose  : Directed self-checking bench with an expected-id scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zeroriscy_irq_controller;

    localparam int N_IRQ = 32;
`ifdef ZERORISCY_IRQ_EDGE_EN
    localparam int c_LAT = 4;
`else
    localparam int c_LAT = 3;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_IRQ-1:0] irq_i;
    logic             m_irq_enable_i;
    logic             irq_ack_i;
    logic             mret_i;
    logic             irq_req_o;
    logic [4:0]       irq_id_o;
    logic [5:0]       csr_cause_o;
    logic [N_IRQ-1:0] irq_pending_o;
    logic             irq_in_service_o;

    int               n_tests = 0;
    int               n_fail  = 0;
    logic [4:0]       exp_q[$];

    zeroriscy_irq_controller #(.N_IRQ(N_IRQ)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .irq_i            (irq_i),
        .m_irq_enable_i   (m_irq_enable_i),
        .irq_ack_i        (irq_ack_i),
        .mret_i           (mret_i),
        .irq_req_o        (irq_req_o),
        .irq_id_o         (irq_id_o),
        .csr_cause_o      (csr_cause_o),
        .irq_pending_o    (irq_pending_o),
        .irq_in_service_o (irq_in_service_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a request and compare it with the oldest expected id.
    task automatic wait_req(input string tag);
        int         n;
        logic [4:0] e;
        n = 0;
        while (!irq_req_o && n < 12) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 32'(irq_req_o), 32'd1);
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_id"}, 32'(irq_id_o), 32'(e));
            check({tag, "_cause"}, 32'(csr_cause_o), 32'({1'b1, e}));
        end
    endtask

    task automatic do_ack(input string tag, input logic [N_IRQ-1:0] irq_next);
        irq_ack_i = 1'b1;
        irq_i     = irq_next;
        tick();
        irq_ack_i = 1'b0;
        check({tag, "_ack_req"}, 32'(irq_req_o), 32'd0);
        check({tag, "_ack_svc"}, 32'(irq_in_service_o), 32'd1);
    endtask

    task automatic do_mret(input string tag);
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        check({tag, "_mret_svc"}, 32'(irq_in_service_o), 32'd0);
        check({tag, "_mret_req"}, 32'(irq_req_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: observed no end of test expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n          = 1'b0;
        irq_i          = '0;
        m_irq_enable_i = 1'b1;
        irq_ack_i      = 1'b0;
        mret_i         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(irq_req_o), 32'd0);
        check("rst_id", 32'(irq_id_o), 32'd0);
        check("rst_cause", 32'(csr_cause_o), 32'h20);
        check("rst_pend", irq_pending_o, 32'd0);
        check("rst_svc", 32'(irq_in_service_o), 32'd0);
        rst_n = 1'b1;

        // Line 0: request latency from the raise of irq_i.
        irq_i = 32'h1;
        exp_q.push_back(5'd0);
        repeat (c_LAT - 1) tick();
        check("lat_early", 32'(irq_req_o), 32'd0);
        tick();
        check("lat_req", 32'(irq_req_o), 32'd1);
        check("lat_pend", irq_pending_o, 32'h1);
        wait_req("l0");
        do_ack("l0", '0);
        do_mret("l0");
        repeat (3) tick();
        check("l0_idle", 32'(irq_req_o), 32'd0);

        // Lines 3 and 7 together: lowest index first.
        irq_i = 32'h88;
        exp_q.push_back(5'd3);
        exp_q.push_back(5'd7);
        wait_req("p3");
        do_ack("p3", 32'h80);
        do_mret("p3");
        wait_req("p7");
        do_ack("p7", '0);
        do_mret("p7");
        repeat (3) tick();

        // MIE drop in REQ retracts the request; the higher priority line wins afterwards.
        irq_i = 32'h80;
        exp_q.push_back(5'd7);
        wait_req("m7");
        irq_i          = 32'h84;
        m_irq_enable_i = 1'b0;
        tick();
        check("mie_drop_req", 32'(irq_req_o), 32'd0);
        repeat (4) tick();
        check("mie_off_req", 32'(irq_req_o), 32'd0);
        check("mie_off_pend", irq_pending_o, 32'h84);
        exp_q.push_back(5'd2);
        m_irq_enable_i = 1'b1;
        wait_req("m2");
        exp_q.push_back(5'd7);
        do_ack("m2", 32'h80);
        do_mret("m2");
        wait_req("m7b");
        do_ack("m7b", '0);
        do_mret("m7b");
        repeat (4) tick();
        check("drain_pend", irq_pending_o, 32'd0);

        // Ack and mret are ignored while IDLE.
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        check("ign_ack_svc", 32'(irq_in_service_o), 32'd0);
        mret_i = 1'b1;
        tick();
        mret_i = 1'b0;
        check("ign_mret_req", 32'(irq_req_o), 32'd0);

`ifndef ZERORISCY_IRQ_EDGE_EN
        // Level mode: dropping the line in REQ keeps the request.
        irq_i = 32'h1;
        exp_q.push_back(5'd0);
        wait_req("lv");
        irq_i = '0;
        repeat (4) tick();
        check("lv_hold_req", 32'(irq_req_o), 32'd1);
        check("lv_hold_id", 32'(irq_id_o), 32'd0);
        do_ack("lv", '0);
        do_mret("lv");
`else
        // Edge mode: a one-cycle pulse is latched while MIE is off.
        m_irq_enable_i = 1'b0;
        irq_i = 32'h20;
        tick();
        irq_i = '0;
        repeat (20) tick();
        check("pulse_pend", irq_pending_o, 32'h20);
        check("pulse_noreq", 32'(irq_req_o), 32'd0);
        exp_q.push_back(5'd5);
        m_irq_enable_i = 1'b1;
        wait_req("e5");
        check("e5_pend", irq_pending_o, 32'h20);
        do_ack("e5", '0);
        check("e5_clr", irq_pending_o, 32'd0);
        do_mret("e5");

        // A new edge coincident with the ack of the same line survives.
        irq_i = 32'h10;
        tick();
        irq_i = '0;
        exp_q.push_back(5'd4);
        wait_req("e4");
        irq_i = 32'h10;
        tick();
        tick();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
        check("e4_svc", 32'(irq_in_service_o), 32'd1);
        check("e4_keep", irq_pending_o & 32'h10, 32'h10);
        exp_q.push_back(5'd4);
        do_mret("e4");
        wait_req("e4b");
        do_ack("e4b", '0);
        do_mret("e4b");
`endif

        // Asynchronous reset while in SERVICE.
        irq_i = 32'h2;
        exp_q.push_back(5'd1);
        wait_req("r1");
        do_ack("r1", 32'h2);
        #2;
        rst_n = 1'b0;
        irq_i = '0;
        #1;
        check("arst_req", 32'(irq_req_o), 32'd0);
        check("arst_id", 32'(irq_id_o), 32'd0);
        check("arst_cause", 32'(csr_cause_o), 32'h20);
        check("arst_pend", irq_pending_o, 32'd0);
        check("arst_svc", 32'(irq_in_service_o), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        check("post_rst_req", 32'(irq_req_o), 32'd0);
        irq_i = 32'h4;
        exp_q.push_back(5'd2);
        wait_req("r2");
        do_ack("r2", '0);
        do_mret("r2");

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
